// File: rtl/pio_input_capture.sv
// Avalon-MM input PIO: synchronises and debounces WIDTH external inputs,
// latches selected edges into a sticky capture register and raises a
// maskable level interrupt while any unmasked captured edge is pending.
//
// Bus handshake: a write is accepted on any rising edge where
// chipselect && !write_n; a read is accepted on any rising edge where
// chipselect && read, and readdata carries the register value from before
// that edge starting on the following cycle (fixed latency 1, no waitrequest).
// readdata holds its value when no read is accepted.
module pio_input_capture #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
    localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;

    // Terminal count: the cycle on which a persistent difference is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (DEBOUNCE_CYCLES > 0) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [1:0]       edge_sel_q, edge_sel_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] new_edges;
    logic [WIDTH-1:0] w1c_mask;
    logic             unused_wdata;

    assign wr_en = chipselect && !write_n;
    assign rd_en = chipselect && read;

    // Bits above WIDTH are accepted on the bus but carry no meaning.
    assign unused_wdata = ^writedata;

    // Two-flop synchroniser: the only logic that looks at in_port.
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
    end

    // Per-bit debounce: a difference must persist DEBOUNCE_CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (DEBOUNCE_CYCLES == 0) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge detect on the cycle stable changes, filtered by the current edge_sel.
    always_comb begin
        rise = stable_d & ~stable_q;
        fall = ~stable_d & stable_q;
        case (edge_sel_q)
            2'd0:    new_edges = rise;
            2'd1:    new_edges = fall;
            default: new_edges = rise | fall;
        endcase
    end

    // Register writes; a fresh edge overrides a simultaneous clear.
    always_comb begin
        irq_mask_d = irq_mask_q;
        edge_sel_d = edge_sel_q;
        w1c_mask   = '0;
        if (wr_en) begin
            case (address)
                ADDR_IRQ_MASK: irq_mask_d = writedata[WIDTH-1:0];
                ADDR_EDGE_CAP: w1c_mask   = writedata[WIDTH-1:0];
                ADDR_EDGE_SEL: edge_sel_d = writedata[1:0];
                default:       ;
            endcase
        end
        edge_capture_d = (edge_capture_q & ~w1c_mask) | new_edges;
    end

    // Read mux samples pre-edge register values; holds when idle.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            case (address)
                ADDR_DATA:     readdata_d = 32'(stable_q);
                ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
                ADDR_EDGE_CAP: readdata_d = 32'(edge_capture_q);
                ADDR_EDGE_SEL: readdata_d = {30'd0, edge_sel_q};
                default:       readdata_d = '0;
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            stable_q       <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            edge_capture_q <= '0;
            irq_mask_q     <= '0;
            edge_sel_q     <= '0;
            readdata_q     <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            stable_q       <= stable_d;
            cnt_q          <= cnt_d;
            edge_capture_q <= edge_capture_d;
            irq_mask_q     <= irq_mask_d;
            edge_sel_q     <= edge_sel_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_pio_input_capture.sv
// Directed bench for pio_input_capture (WIDTH=8, DEBOUNCE_CYCLES=4).
// All stimulus changes 1 time unit after a rising edge; outputs are sampled
// at the same point, so the value seen reflects the edge just taken.
module tb_pio_input_capture;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             read;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    pio_input_capture #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .read(read),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Driver tasks: entered and left 1 unit after a rising edge.
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = addr;
        writedata  = data;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = addr;
        tick(1);
        chipselect = 1'b0;
        read       = 1'b0;
        e = exp_q.pop_front();
        check(tag, readdata, e);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        read       = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_port    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset defaults
        check("rst_irq", {31'd0, irq}, 32'd0);
        bus_read("rst_data", 2'd0, 32'h0);
        bus_read("rst_mask", 2'd1, 32'h0);
        bus_read("rst_cap",  2'd2, 32'h0);
        bus_read("rst_sel",  2'd3, 32'h0);

        // Debounce latency: stable flips at k+5; readdata trails stable by one edge
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 2'd0;
        in_port    = 8'h01;
        for (int n = 1; n <= 7; n++) begin
            tick(1);
            check($sformatf("deb_lat_%0d", n), readdata, (n >= 7) ? 32'h01 : 32'h00);
        end
        chipselect = 1'b0;
        read       = 1'b0;
        bus_read("deb_cap", 2'd2, 32'h01);
        check("deb_irq", {31'd0, irq}, 32'd0);

        // Glitch rejection: bit3 high for 3 sampled cycles
        bus_write(2'd2, 32'h01);
        bus_read("glitch_clr", 2'd2, 32'h00);
        in_port = 8'h09;
        tick(3);
        in_port = 8'h01;
        tick(10);
        bus_read("glitch_data", 2'd0, 32'h01);
        bus_read("glitch_cap",  2'd2, 32'h00);
        check("glitch_irq", {31'd0, irq}, 32'd0);

        // Falling-edge select with irq on bit7
        bus_write(2'd3, 32'h1);
        bus_write(2'd1, 32'h80);
        in_port = 8'h81;
        tick(10);
        bus_read("fall_rise_ignored", 2'd2, 32'h00);
        check("fall_irq_pre", {31'd0, irq}, 32'd0);
        in_port = 8'h01;
        for (int n = 1; n <= 6; n++) begin
            tick(1);
            check($sformatf("fall_irq_%0d", n), {31'd0, irq}, (n >= 6) ? 32'd1 : 32'd0);
        end
        tick(4);
        bus_read("fall_cap", 2'd2, 32'h80);

        // Either-edge select, then W1C colliding with a new bit0 edge
        bus_write(2'd3, 32'h2);
        in_port = 8'h00;
        tick(10);
        bus_read("both_cap", 2'd2, 32'h81);
        in_port = 8'h01;
        tick(5);
        bus_write(2'd2, 32'h01);
        tick(2);
        bus_read("w1c_collide", 2'd2, 32'h81);
        check("w1c_collide_irq", {31'd0, irq}, 32'd1);
        bus_write(2'd2, 32'h81);
        bus_read("w1c_clear", 2'd2, 32'h00);
        check("w1c_clear_irq", {31'd0, irq}, 32'd0);

        // Register map corners
        bus_write(2'd0, 32'hFF);
        bus_read("data_ro", 2'd0, 32'h01);
        chipselect = 1'b1;
        read       = 1'b1;
        write_n    = 1'b0;
        address    = 2'd1;
        writedata  = 32'h3C;
        tick(1);
        chipselect = 1'b0;
        read       = 1'b0;
        write_n    = 1'b1;
        check("rw_same_old", readdata, 32'h80);
        bus_read("rw_same_new", 2'd1, 32'h3C);
        bus_write(2'd1, 32'hFFFF_FF00);
        bus_read("mask_upper", 2'd1, 32'h00);
        bus_read("sel_readback", 2'd3, 32'h2);

        // Reset mid-debounce and mid-read: count restarts after release
        in_port = 8'h05;
        tick(4);
        reset      = 1'b1;
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 2'd0;
        tick(1);
        check("rst_mid_read", readdata, 32'h0);
        reset = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            tick(1);
            check($sformatf("rst_deb_%0d", n), readdata, (n >= 7) ? 32'h05 : 32'h00);
        end
        chipselect = 1'b0;
        read       = 1'b0;
        bus_read("rst_deb_cap", 2'd2, 32'h05);
        check("rst_deb_irq", {31'd0, irq}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
